// File: rtl/boom_sram_mem.sv
// Word-organised SRAM model behind the BOOM memory bridge: byte-enable writes,
// RD_LATENCY-deep read pipeline, sticky out-of-range capture. Counters: BOOM_SRAM_MEM_STATS_EN.
module boom_sram_mem #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    MEM_DEPTH_WORDS = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8000_0000,
  parameter int                    RD_LATENCY      = 1
) (
  input  logic                    clock,
  input  logic                    reset_wire_reset,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    oob_o,
  output logic [ADDR_WIDTH-1:0]   oob_addr_o,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BE_W);
  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] offset_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic [IDX_W-1:0]      widx_s;
  logic                  in_range_s;
  logic                  rd_s;
  logic                  wr_s;
  logic [DATA_WIDTH-1:0] mem_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] wr_word_s;

  logic [RD_LATENCY-1:0] vld_r;
  logic [DATA_WIDTH-1:0] dat_r [RD_LATENCY];
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  oob_r;
  logic [ADDR_WIDTH-1:0] oob_addr_r;

  // Address decode and merged write word.
  always_comb begin
    offset_s   = addr_i - BASE_ADDR;
    idx_s      = offset_s >> OFFS;
    widx_s     = idx_s[IDX_W-1:0];
    // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets but fail the first term.
    in_range_s = (addr_i >= BASE_ADDR) && ({1'b0, idx_s} < DEPTH_L);
    rd_s       = req_i && !we_i;
    wr_s       = req_i && we_i;
    mem_word_s = mem_r[widx_s];
    if (in_range_s) begin
      rd_word_s = mem_word_s;
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
    wr_word_s = mem_word_s;
    for (int k = 0; k < BE_W; k++) begin
      if (be_i[k]) begin
        wr_word_s[8*k +: 8] = wdata_i[8*k +: 8];
      end else begin
        wr_word_s[8*k +: 8] = mem_word_s[8*k +: 8];
      end
    end
  end

  // Array storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_s && in_range_s) begin
      mem_r[widx_s] <= wr_word_s;
    end
  end

  // Read data payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clock) begin
    dat_r[0] <= rd_word_s;
    for (int i = 1; i < RD_LATENCY; i++) begin
      dat_r[i] <= dat_r[i-1];
    end
  end

  // Read valid pipeline and output register; reset discards reads in flight.
  always_ff @(posedge clock or posedge reset_wire_reset) begin
    if (reset_wire_reset) begin
      vld_r   <= {RD_LATENCY{1'b0}};
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      vld_r[0] <= rd_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
      if (vld_r[RD_LATENCY-1]) begin
        rdata_r <= dat_r[RD_LATENCY-1];
      end
    end
  end

  // Sticky out-of-range flag keeps the first offending address.
  always_ff @(posedge clock or posedge reset_wire_reset) begin
    if (reset_wire_reset) begin
      oob_r      <= 1'b0;
      oob_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (req_i && !in_range_s && !oob_r) begin
      oob_r      <= 1'b1;
      oob_addr_r <= addr_i;
    end
  end

  assign rdata_o    = rdata_r;
  assign oob_o      = oob_r;
  assign oob_addr_o = oob_addr_r;

`ifdef BOOM_SRAM_MEM_STATS_EN
  logic [31:0] rd_cnt_r;
  logic [31:0] wr_cnt_r;

  // Saturating access counters; out-of-range accesses count too.
  always_ff @(posedge clock or posedge reset_wire_reset) begin
    if (reset_wire_reset) begin
      rd_cnt_r <= 32'd0;
      wr_cnt_r <= 32'd0;
    end else begin
      if (rd_s && (rd_cnt_r != 32'hFFFF_FFFF)) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
      if (wr_s && (wr_cnt_r != 32'hFFFF_FFFF)) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_r;
  assign wr_cnt_o = wr_cnt_r;
`else
  assign rd_cnt_o = 32'd0;
  assign wr_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_boom_sram_mem.sv
// Bench for boom_sram_mem: three instances (RD_LATENCY 1, 2, 3) share one
// stimulus stream; a read scoreboard predicts each instance's return cycle.
module tb_boom_sram_mem;

  localparam int          AW    = 32;
  localparam int          DW    = 64;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef BOOM_SRAM_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [7:0]  be    = 8'd0;
  logic [63:0] wdata = 64'd0;

  logic [63:0] rdata    [3];
  logic        oob      [3];
  logic [31:0] oob_addr [3];
  logic [31:0] rdc      [3];
  logic [31:0] wrc      [3];

  boom_sram_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_WORDS(DEPTH),
                  .BASE_ADDR(BASE), .RD_LATENCY(1)) u1 (
    .clock(clock), .reset_wire_reset(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .rdata_o(rdata[0]), .oob_o(oob[0]),
    .oob_addr_o(oob_addr[0]), .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0]));

  boom_sram_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_WORDS(DEPTH),
                  .BASE_ADDR(BASE), .RD_LATENCY(2)) u2 (
    .clock(clock), .reset_wire_reset(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .rdata_o(rdata[1]), .oob_o(oob[1]),
    .oob_addr_o(oob_addr[1]), .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1]));

  boom_sram_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_WORDS(DEPTH),
                  .BASE_ADDR(BASE), .RD_LATENCY(3)) u3 (
    .clock(clock), .reset_wire_reset(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .rdata_o(rdata[2]), .oob_o(oob[2]),
    .oob_addr_o(oob_addr[2]), .rd_cnt_o(rdc[2]), .wr_cnt_o(wrc[2]));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] d;
    int          k;
  } ent_t;

  ent_t        sbq [$];
  int          rp   [3];
  logic [63:0] hold [3];
  logic [63:0] model [int];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd = 32'd0;
  logic [31:0] exp_wr = 32'd0;
  logic        oob_e  = 1'b0;
  logic [31:0] oob_ae = 32'd0;

  function automatic bit inr(input logic [31:0] a);
    logic [31:0] ix;
    ix = (a - BASE) >> 3;
    return (a >= BASE) && (ix < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] ix;
    ix = (a - BASE) >> 3;
    return int'(ix);
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and retire any read due there.
  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rp[i]   = sbq.size();
        hold[i] = 64'd0;
      end else if (rp[i] < sbq.size() && (sbq[rp[i]].k + 2 + i) == cyc) begin
        hold[i] = sbq[rp[i]].d;
        rp[i]++;
      end
      chk($sformatf("rdata_lat%0d", i + 1), rdata[i], hold[i]);
    end
  endtask

  task automatic note_oob(input logic [31:0] a);
    if (!inr(a) && !oob_e) begin
      oob_e  = 1'b1;
      oob_ae = a;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] b, input logic [63:0] d);
    logic [63:0] w;
    tick();
    req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    if (inr(a)) begin
      w = model.exists(widx(a)) ? model[widx(a)] : 64'd0;
      for (int k = 0; k < 8; k++) begin
        if (b[k]) w[8*k +: 8] = d[8*k +: 8];
      end
      model[widx(a)] = w;
    end
    note_oob(a);
    exp_wr = sat(exp_wr);
  endtask

  task automatic rd(input logic [31:0] a);
    ent_t e;
    tick();
    req = 1'b1; we = 1'b0; addr = a; be = 8'h00; wdata = 64'd0;
    e.d = inr(a) ? model[widx(a)] : 64'd0;
    e.k = cyc;
    sbq.push_back(e);
    note_oob(a);
    exp_rd = sat(exp_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      req = 1'b0; we = 1'b0;
    end
  endtask

  task automatic chk_stat(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_oob"}, {63'd0, oob[i]}, {63'd0, oob_e});
      chk({tag, "_oob_addr"}, {32'd0, oob_addr[i]}, {32'd0, oob_ae});
      chk({tag, "_rd_cnt"}, {32'd0, rdc[i]}, {32'd0, (STATS ? exp_rd : 32'd0)});
      chk({tag, "_wr_cnt"}, {32'd0, wrc[i]}, {32'd0, (STATS ? exp_wr : 32'd0)});
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    idle(3);
    chk_stat("reset");
    @(posedge clock);
    #2 rst = 1'b0;

    // Full write then read back.
    wr(32'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF);
    rd(32'h8000_0010);
    idle(5);
    chk_stat("t1");

    // Byte enables, no-op write, misaligned read of the same word.
    wr(32'h8000_0008, 8'hFF, 64'h0);
    wr(32'h8000_0008, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(32'h8000_0008);
    wr(32'h8000_0008, 8'h00, 64'h5555_5555_5555_5555);
    rd(32'h8000_000B);
    idle(5);

    // Back-to-back reads return in order and the last value holds.
    wr(32'h8000_0000, 8'hFF, 64'd1);
    wr(32'h8000_0008, 8'hFF, 64'd2);
    wr(32'h8000_0010, 8'hFF, 64'd3);
    rd(32'h8000_0000);
    rd(32'h8000_0008);
    rd(32'h8000_0010);
    idle(8);

    // Out-of-range write below BASE and read just past the top.
    wr(32'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    rd(32'h8000_0000 + DEPTH * 8);
    idle(5);
    chk_stat("t4a");
    wr(32'h9000_0000, 8'hFF, 64'h1);
    rd(32'h8000_0000);
    idle(5);
    chk_stat("t4b");

    // Reset mid-cycle with a read in flight.
    wr(32'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF);
    rd(32'h8000_0010);
    tick();
    req = 1'b0; we = 1'b0;
    @(posedge clock);
    #2 rst = 1'b1;
    exp_rd = 32'd0; exp_wr = 32'd0; oob_e = 1'b0; oob_ae = 32'd0;
    #1;
    for (int i = 0; i < 3; i++) chk("rdata_async_rst", rdata[i], 64'd0);
    chk_stat("t5_rst");
    idle(2);
    @(posedge clock);
    #2 rst = 1'b0;
    idle(6);
    chk_stat("t5_post");

    // Data survives reset; access counting.
    rd(32'h8000_0010);
    wr(32'h8000_0018, 8'hFF, 64'h1111_1111_1111_1111);
    wr(32'h8000_0020, 8'hFF, 64'h2222_2222_2222_2222);
    wr(32'h8000_0018, 8'h81, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(32'h8000_0000);
    rd(32'h8000_0018);
    rd(32'h8000_0020);
    rd(32'h8000_001C);
    rd(32'h8000_2008);
    idle(5);
    chk_stat("t6_cnt");

    // Counter saturation.
    idle(1);
`ifdef BOOM_SRAM_MEM_STATS_EN
    force u1.rd_cnt_r = 32'hFFFF_FFFE;
    force u2.rd_cnt_r = 32'hFFFF_FFFE;
    force u3.rd_cnt_r = 32'hFFFF_FFFE;
    #1;
    release u1.rd_cnt_r;
    release u2.rd_cnt_r;
    release u3.rd_cnt_r;
`endif
    exp_rd = 32'hFFFF_FFFE;
    rd(32'h8000_0000);
    rd(32'h8000_0008);
    idle(1);
    chk_stat("t6_sat2");
    rd(32'h8000_0010);
    idle(5);
    chk_stat("t6_sat3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boom_sram_mem.md
Name: boom_sram_mem

Overview:
- Downstream memory model for the BOOM memory-bridge stage. It consumes the bridge's single-port request interface (req/we/addr/be/wdata) and returns read data on the bridge's data input.
- It holds a word-organised SRAM array with byte-enable writes, a configurable read-latency pipeline, and sticky out-of-range error capture.
- It instantiates next to the bridge in the memory top and is the sole backing store for axi4_mem_0 traffic.

Parameters:
- ADDR_WIDTH, 32, byte-address width of addr_i.
- DATA_WIDTH, 64, word width in bits; multiple of 8; power of two.
- MEM_DEPTH_WORDS, 65536, number of DATA_WIDTH words in the array.
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- RD_LATENCY, 1, cycles from accepted read to rdata_o update; legal range 1..4.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_wire_reset  in  1  asynchronous, active-high reset.
- req_i  in  1  access request; sampled every cycle, no backpressure.
- we_i  in  1  1 = write, 0 = read; qualified by req_i.
- addr_i  in  ADDR_WIDTH  byte address.
- be_i  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- wdata_i  in  DATA_WIDTH  write data.
- rdata_o  out  DATA_WIDTH  read data.
- oob_o  out  1  sticky flag: an out-of-range access occurred.
- oob_addr_o  out  ADDR_WIDTH  address of the first out-of-range access.
- rd_cnt_o  out  32  read counter (optional feature).
- wr_cnt_o  out  32  write counter (optional feature).

Behaviour:
- Decode:
  - OFFS = log2(DATA_WIDTH/8).
  - idx = (addr_i - BASE_ADDR) >> OFFS, computed at ADDR_WIDTH width.
  - addr_i[OFFS-1:0] is ignored, so misaligned addresses access the containing word.
  - in_range = (addr_i >= BASE_ADDR) && (idx < MEM_DEPTH_WORDS). This uses an unsigned compare, so addresses below BASE never wrap into range.
- Write (req_i && we_i && in_range): at the clock edge, byte k of mem[idx] takes wdata_i[8k+7:8k] for every be_i[k]=1. Other bytes are unchanged. be_i = 0 is a legal no-op write.
- Read (req_i && !we_i):
  - The array is sampled at the request edge into stage 0 of a RD_LATENCY-deep {valid, data} shift pipeline.
  - rdata_o loads the last-stage data exactly RD_LATENCY cycles after the request cycle.
  - rdata_o holds its value until the next read completes.
  - One request is accepted per cycle, and back-to-back reads return in order, one per cycle.
- Read and write are mutually exclusive per cycle (single port). A write at address A followed by a read at A on the next cycle returns the new data.
- Out-of-range access:
  - A write is dropped and the array is unchanged.
  - A read returns all-zeros at the normal latency.
  - If oob_o is 0: oob_o is set to 1 the next cycle and oob_addr_o captures addr_i.
  - Later out-of-range accesses do not update oob_addr_o.
  - oob_o clears only on reset.
- Reset (async assert, released synchronously by the environment):
  - rdata_o = 0, every pipeline valid bit = 0, oob_o = 0, oob_addr_o = 0, rd_cnt_o = 0, wr_cnt_o = 0.
  - Array contents are not reset.
  - Reads in flight when reset asserts are discarded; rdata_o stays 0 and those reads never return after reset deasserts.
- req_i = 0: no state changes except pipeline advance.
- No X propagation: a read of a never-written in-range word returns the array's uninitialised value, and the bench must not check it.

Optional Feature:
- Macro: BOOM_SRAM_MEM_STATS_EN.
- Defined:
  - rd_cnt_o increments by 1 per accepted read; wr_cnt_o increments by 1 per accepted write.
  - Out-of-range accesses are counted.
  - Both counters saturate at 32'hFFFF_FFFF with no wrap.
- Undefined: rd_cnt_o and wr_cnt_o are tied to 0, no counter flops are synthesised, and the ports remain present.

Test Plan:
1. Reset, then write addr 0x8000_0010, be 8'hFF, data 64'h0123_4567_89AB_CDEF, then read the same address (RD_LATENCY=1) -> rdata_o = 64'h0123_4567_89AB_CDEF one cycle after the read request; oob_o = 0.
2. Write 64'h0 with be 8'hFF, then write 64'hFFFF_FFFF_FFFF_FFFF with be 8'h0F at 0x8000_0008, then read -> rdata_o = 64'h0000_0000_FFFF_FFFF. A read at 0x8000_000B returns the same word.
3. RD_LATENCY=3, reads to words 0, 1, 2 on consecutive cycles (preloaded 1, 2, 3) -> rdata_o = 1, 2, 3 on cycles +3, +4, +5, and holds 3 afterwards.
4. Write to 0x7FFF_FFF8, then read 0x8000_0000 + MEM_DEPTH_WORDS*8 -> the write is dropped, the read returns 0, oob_o = 1, oob_addr_o = 0x7FFF_FFF8 (first offender retained).
5. RD_LATENCY=2, issue a read, assert reset_wire_reset asynchronously mid-cycle one cycle later -> rdata_o = 0 immediately and stays 0 after deassert with no late return. oob_o = 0, and array data written before reset reads back intact.
6. With BOOM_SRAM_MEM_STATS_EN: 5 reads, 3 writes, 1 out-of-range read -> rd_cnt_o = 6, wr_cnt_o = 3. With the counters forced near saturation, 32'hFFFF_FFFE plus 2 reads -> rd_cnt_o = 32'hFFFF_FFFF. Without the macro, both counters read 0.
